// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: period and high time load through a
// valid/ready slot and take effect only at a period boundary or while idle.
module clock_divider_prog #(
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 14000,
  parameter int DEFAULT_HIGH   = 7000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_pending
);

  localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_HIGH   = WIDTH'(DEFAULT_HIGH);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur_period;
  logic [WIDTH-1:0] r_cur_high;
  logic [WIDTH-1:0] r_pend_period;
  logic [WIDTH-1:0] r_pend_high;
  logic             r_pending;
  logic             r_running;
  logic             r_clk_out;
  logic             r_tick;

  logic [WIDTH-1:0] w_clamp_period;
  logic [WIDTH-1:0] w_clamp_high;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_wrap;
  logic             w_apply;

  // Clamp so every period has at least one high and one low cycle.
  always_comb begin
    w_clamp_period = (cfg_period < WIDTH'(2)) ? WIDTH'(2) : cfg_period;
    if (cfg_high == '0)
      w_clamp_high = WIDTH'(1);
    else if (cfg_high >= w_clamp_period)
      w_clamp_high = w_clamp_period - WIDTH'(1);
    else
      w_clamp_high = cfg_high;
  end

  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_accept  = cfg_valid & ~r_pending;
  assign w_wrap    = (r_cnt == r_cur_period - WIDTH'(1));
  assign w_apply   = r_pending & (~en | ~r_running | w_wrap);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt         <= '0;
      r_cur_period  <= DEF_PERIOD;
      r_cur_high    <= DEF_HIGH;
      r_pend_period <= DEF_PERIOD;
      r_pend_high   <= DEF_HIGH;
      r_pending     <= 1'b0;
      r_running     <= 1'b0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
    end else begin
      // Accept and apply are mutually exclusive: accept needs an empty slot.
      if (w_accept) begin
        r_pend_period <= w_clamp_period;
        r_pend_high   <= w_clamp_high;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_cur_period  <= r_pend_period;
        r_cur_high    <= r_pend_high;
        r_pending     <= 1'b0;
      end

      if (!en) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
        r_running <= 1'b0;
      end else if (!r_running || w_wrap) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b1;
        r_tick    <= 1'b1;
        r_running <= 1'b1;
      end else begin
        r_cnt     <= w_cnt_inc;
        r_clk_out <= (w_cnt_inc < r_cur_high);
        r_tick    <= 1'b0;
      end
    end
  end

  assign cfg_ready   = ~r_pending;
  assign cfg_pending = r_pending;
  assign clk_out     = r_clk_out;
  assign tick        = r_tick;
  assign running     = r_running;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench: stimulus queues expected period shapes, a negedge monitor
// measures each completed period between ticks and compares.
module tb_clock_divider_prog;

  localparam int WIDTH = 16;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic             cfg_pending;

  clock_divider_prog #(
    .WIDTH(WIDTH),
    .DEFAULT_PERIOD(14000),
    .DEFAULT_HIGH(7000)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .clk_out(clk_out),
    .tick(tick),
    .running(running),
    .cfg_pending(cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int period;
    int high;
  } shape_t;

  shape_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic expect_periods(input int p, input int h, input int n);
    shape_t s;
    s.period = p;
    s.high   = h;
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  // Offer a config while idle; it is accepted on one edge, applied on the next.
  task automatic program_idle(input int p, input int h);
    cfg_valid  = 1'b1;
    cfg_period = WIDTH'(p);
    cfg_high   = WIDTH'(h);
    cycles(1);
    cfg_valid  = 1'b0;
    @(negedge clk_in);
    chk("idle_accept_pending", int'(cfg_pending), 1);
    chk("idle_accept_ready", int'(cfg_ready), 0);
    cycles(1);
    @(negedge clk_in);
    chk("idle_apply_pending", int'(cfg_pending), 0);
    chk("idle_apply_ready", int'(cfg_ready), 1);
  endtask

  task automatic chk_drained();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: a tick closes the previous period; running low aborts it.
  initial begin : monitor
    bit     in_period = 0;
    bit     seen_low  = 0;
    bit     glitch    = 0;
    int     cyc       = 0;
    int     hi        = 0;
    shape_t s;
    forever begin
      @(negedge clk_in);
      if (tick === 1'b1) begin
        if (in_period) begin
          $display("period done: len=%0d high=%0d glitch=%0d", cyc, hi, glitch);
          if (exp_q.size() == 0) begin
            chk("unexpected_period", 1, 0);
          end else begin
            s = exp_q.pop_front();
            chk("period_len", cyc, s.period);
            chk("period_high", glitch ? -1 : hi, s.high);
          end
        end
        in_period = 1;
        cyc       = 1;
        hi        = (clk_out === 1'b1) ? 1 : 0;
        seen_low  = (clk_out !== 1'b1);
        glitch    = 0;
      end else if (in_period) begin
        if (running !== 1'b1) begin
          in_period = 0;
        end else begin
          cyc++;
          if (clk_out === 1'b1) begin
            if (seen_low) glitch = 1;
            else hi++;
          end else begin
            seen_low = 1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset      = 1'b1;
    en         = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cycles(3);
    @(negedge clk_in);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_pending", int'(cfg_pending), 0);
    chk("rst_ready", int'(cfg_ready), 1);

    // Defaults: 14000/7000, first rise one cycle after en.
    reset = 1'b0;
    en    = 1'b1;
    cycles(1);
    chk("start_tick", int'(tick), 1);
    chk("start_clk_out", int'(clk_out), 1);
    chk("start_running", int'(running), 1);
    expect_periods(14000, 7000, 2);
    cycles(28003);
    en = 1'b0;
    cycles(2);
    chk_drained();

    // Reconfigure mid-period at cnt=4, with a second request held while pending.
    program_idle(10, 3);
    en = 1'b1;
    cycles(1);
    chk("run10_tick", int'(tick), 1);
    expect_periods(10, 3, 1);
    expect_periods(6, 2, 1);
    expect_periods(4, 1, 3);
    cycles(4);
    cfg_valid  = 1'b1;
    cfg_period = WIDTH'(6);
    cfg_high   = WIDTH'(2);
    cycles(1);
    cfg_period = WIDTH'(4);
    cfg_high   = WIDTH'(1);
    @(negedge clk_in);
    chk("run_accept_pending", int'(cfg_pending), 1);
    chk("run_accept_ready", int'(cfg_ready), 0);
    cycles(4);
    @(negedge clk_in);
    chk("held_pending_cnt9", int'(cfg_pending), 1);
    chk("low_phase_cnt9", int'(clk_out), 0);
    cycles(1);
    @(negedge clk_in);
    chk("boundary_tick", int'(tick), 1);
    chk("boundary_pending", int'(cfg_pending), 0);
    chk("boundary_ready", int'(cfg_ready), 1);
    cycles(1);
    cfg_valid = 1'b0;
    @(negedge clk_in);
    chk("second_accept_pending", int'(cfg_pending), 1);
    cycles(17);
    en = 1'b0;
    cycles(2);
    chk_drained();

    // Clamp 1/0 -> 2/1.
    program_idle(1, 0);
    en = 1'b1;
    cycles(1);
    expect_periods(2, 1, 4);
    cycles(8);
    en = 1'b0;
    cycles(2);
    chk_drained();

    // Clamp 5/9 -> 5/4, then drop en in the high phase.
    program_idle(5, 9);
    en = 1'b1;
    cycles(1);
    expect_periods(5, 4, 2);
    cycles(10);
    cycles(1);
    @(negedge clk_in);
    chk("pre_drop_clk_out", int'(clk_out), 1);
    chk("pre_drop_running", int'(running), 1);
    en = 1'b0;
    cycles(1);
    @(negedge clk_in);
    chk("drop_clk_out", int'(clk_out), 0);
    chk("drop_running", int'(running), 0);
    chk("drop_tick", int'(tick), 0);
    chk_drained();

    // Config while idle, then re-enable into a fresh period.
    program_idle(8, 5);
    en = 1'b1;
    cycles(1);
    chk("reen_tick", int'(tick), 1);
    chk("reen_clk_out", int'(clk_out), 1);
    expect_periods(8, 5, 2);
    cycles(16);

    // Reset alongside en and cfg_valid: no accept, defaults restored.
    reset      = 1'b1;
    cfg_valid  = 1'b1;
    cfg_period = WIDTH'(3);
    cfg_high   = WIDTH'(1);
    cycles(1);
    @(negedge clk_in);
    chk("rst2_clk_out", int'(clk_out), 0);
    chk("rst2_tick", int'(tick), 0);
    chk("rst2_running", int'(running), 0);
    chk("rst2_pending", int'(cfg_pending), 0);
    chk("rst2_ready", int'(cfg_ready), 1);
    chk_drained();
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cycles(1);
    chk("rst2_start_tick", int'(tick), 1);
    expect_periods(14000, 7000, 1);
    cycles(14000);
    en = 1'b0;
    cycles(2);
    chk_drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
